aes_inv_cipher: RTL and testbench

- Iterative AES-128 inverse cipher (decryptor). Counterpart of the team's AES encryption top: it takes a 128-bit ciphertext and key and returns the plaintext over the same start/finish handshake.
- Computes one key-expansion step per clock to reach round key 10, then runs one inverse round per clock while regenerating round keys backwards.
- Sits beside the encryptor under the AES/SHA3 top-level controller.

---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes_inv_round.sv | 61 ++++++
 rtl/aes_inv_cipher.sv | 120 ++++++++++++
 tb/tb_aes_inv_cipher.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions for the inverse cipher.
//   - state_e       : controller states (S_IDLE, S_KEYEXP, S_DEC, S_DONE)
//   - rcon_byte     : round constant Rcon[1..10] (0 for any other index)
//   - xtime, gmul   : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 (0x11b)
//   - sbox/inv_sbox : S-box and its inverse, built from the field inverse
//                     and the affine map rather than a stored table
//   - sub_word, rot_word : key-schedule word helpers
package aes_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_KEYEXP = 2'd1,
    S_DEC    = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input logic [2:0] n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 3'd1) ^ rotl8(v, 3'd2) ^ rotl8(v, 3'd3) ^ rotl8(v, 3'd4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 3'd1) ^ rotl8(a, 3'd3) ^ rotl8(a, 3'd6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES-128 inverse round plus one reverse
// key-schedule step.
//   data      : current state (byte 0 in [127:120], column-major)
//   rk_i      : round key i held by the controller
//   rcon      : Rcon[i] used to undo the expansion step
//   last      : final round (InvMixColumns skipped)
//   data_next : InvMixColumns(InvSubBytes(InvShiftRows(data)) ^ rk_prev)
//   rk_prev   : round key i-1, which is also the key added in this round
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] rk_i,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] data_next,
  output logic [127:0] rk_prev
);

  logic [31:0]  w0p_s, w1p_s, w2p_s, w3p_s;
  logic [127:0] sub_s, add_s, mix_s;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Undo one forward expansion step; w3' must be formed first since w0' uses it.
  always_comb begin
    w3p_s   = rk_i[31:0]  ^ rk_i[63:32];
    w2p_s   = rk_i[63:32] ^ rk_i[95:64];
    w1p_s   = rk_i[95:64] ^ rk_i[127:96];
    w0p_s   = rk_i[127:96] ^ sub_word(rot_word(w3p_s)) ^ {rcon, 24'h000000};
    rk_prev = {w0p_s, w1p_s, w2p_s, w3p_s};
  end

  // Inverse round datapath; row r of column c comes from column (c - r) mod 4.
  always_comb begin
    sub_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_s[127-8*(4*c+r) -: 8] = inv_sbox(data[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    add_s = sub_s ^ rk_prev;
    mix_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      mix_s[127-32*c -: 32] = inv_mix_col(add_s[127-32*c -: 32]);
    end
    if (last) data_next = add_s;
    else      data_next = mix_s;
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryptor.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   cipher : ciphertext, key : cipher key (both FIPS-197 byte order)
//   start  : request, sampled only when idle
//   plain  : recovered plaintext, held until the next run completes
//   finish : one-cycle done pulse, busy : high whenever not idle
// Ten forward key steps reach round key 10, then ten inverse rounds run
// while the round key is walked back to the cipher key.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] cipher,
  input  logic [127:0] key,
  input  logic         start,
  output logic [127:0] plain,
  output logic         finish,
  output logic         busy
);

  state_e       state_r;
  logic [3:0]   cnt_r;
  logic [127:0] data_r, rk_r, plain_r;
  logic         finish_r, busy_r;

  logic [31:0]  fw0_s, fw1_s, fw2_s, fw3_s;
  logic [7:0]   fwd_rcon_s, dec_rcon_s;
  logic         dec_last_s;
  logic [127:0] fwd_rk_s, dec_data_s, dec_rk_s;

  // Forward key-expansion step using Rcon[cnt_r + 1].
  always_comb begin
    fwd_rcon_s = rcon_byte(cnt_r + 4'd1);
    fw0_s      = rk_r[127:96] ^ sub_word(rot_word(rk_r[31:0])) ^ {fwd_rcon_s, 24'h000000};
    fw1_s      = rk_r[95:64] ^ fw0_s;
    fw2_s      = rk_r[63:32] ^ fw1_s;
    fw3_s      = rk_r[31:0]  ^ fw2_s;
    fwd_rk_s   = {fw0_s, fw1_s, fw2_s, fw3_s};
  end

  // Round index r = 9 - cnt_r, so the reverse step needs Rcon[10 - cnt_r].
  always_comb begin
    dec_rcon_s = rcon_byte(4'd10 - cnt_r);
    dec_last_s = (cnt_r == 4'd9);
  end

  aes_inv_round u_round (
    .data      (data_r),
    .rk_i      (rk_r),
    .rcon      (dec_rcon_s),
    .last      (dec_last_s),
    .data_next (dec_data_s),
    .rk_prev   (dec_rk_s)
  );

  // Controller: finish is registered off S_DONE, so it pulses on the
  // following (idle) cycle, 21 cycles after the accepting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      data_r   <= 128'h0;
      rk_r     <= 128'h0;
      plain_r  <= 128'h0;
      finish_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      finish_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            data_r  <= cipher;
            rk_r    <= key;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= S_KEYEXP;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_KEYEXP: begin
          rk_r <= fwd_rk_s;
          if (cnt_r == 4'd9) begin
            data_r  <= data_r ^ fwd_rk_s;
            cnt_r   <= 4'd0;
            state_r <= S_DEC;
          end else begin
            cnt_r   <= cnt_r + 4'd1;
          end
        end
        S_DEC: begin
          data_r <= dec_data_s;
          rk_r   <= dec_rk_s;
          if (cnt_r == 4'd9) begin
            plain_r <= dec_data_s;
            state_r <= S_DONE;
          end else begin
            cnt_r   <= cnt_r + 4'd1;
          end
        end
        S_DONE: begin
          finish_r <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign plain  = plain_r;
  assign finish = finish_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher. A reference AES-128 encryptor built
// from field arithmetic produces ciphertexts for random plaintexts; the
// driver pushes the original plaintext (and the expected round key 10)
// into queues, and a monitor pops and compares on every finish pulse.
module tb_aes_inv_cipher;
  import aes_pkg::*;

  logic         clk;
  logic         rst;
  logic [127:0] cipher;
  logic [127:0] key;
  logic         start;
  logic [127:0] plain;
  logic         finish;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] cycle_cnt = 32'd0;

  logic [127:0] exp_q[$];
  logic [31:0]  tag_q[$];
  logic [127:0] rk_q[$];

  logic [7:0] sb[256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_inv_cipher dut (
    .clk    (clk),
    .rst    (rst),
    .cipher (cipher),
    .key    (key),
    .start  (start),
    .plain  (plain),
    .finish (finish),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 32'd1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int x = int'(a);
    int y = int'(b);
    while (y != 0) begin
      if ((y & 1) != 0) acc = acc ^ x;
      x = x << 1;
      if ((x & 32'h100) != 0) x = x ^ 32'h11b;
      y = y >> 1;
    end
    return acc[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] o;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sb[x] = o;
    end
  endtask

  function automatic logic [127:0] ref_round_key(input logic [127:0] k, input int rnd);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t  = t ^ {rc, 24'h000000};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [127:0] rk;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
          s[4*c+0] = m_mul(t[0], 8'h02) ^ m_mul(t[1], 8'h03) ^ t[2] ^ t[3];
          s[4*c+1] = t[0] ^ m_mul(t[1], 8'h02) ^ m_mul(t[2], 8'h03) ^ t[3];
          s[4*c+2] = t[0] ^ t[1] ^ m_mul(t[2], 8'h02) ^ m_mul(t[3], 8'h03);
          s[4*c+3] = m_mul(t[0], 8'h03) ^ t[1] ^ t[2] ^ m_mul(t[3], 8'h02);
        end
      end
      rk = ref_round_key(k, rnd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && finish) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_finish");
      end else begin
        check("plain", plain, exp_q.pop_front());
        check("latency", 128'(cycle_cnt - tag_q.pop_front()), 128'd22);
      end
    end
    if (rst && dut.state_r == S_DEC && dut.cnt_r == 4'd0) begin
      if (rk_q.size() == 0) fail_now("unexpected_dec_entry");
      else check("rk10", dut.rk_r, rk_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; waits for idle, then presents one request cycle.
  task automatic issue(input logic [127:0] k, input logic [127:0] ct,
                       input logic [127:0] exp_pt, input logic [127:0] exp_rk);
    int guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now("issue_wait_idle");
    key    = k;
    cipher = ct;
    start  = 1'b1;
    exp_q.push_back(exp_pt);
    tag_q.push_back(cycle_cnt);
    rk_q.push_back(exp_rk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail_now("drain");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    logic [127:0] rk, rpt, rct;
    logic [31:0] base;

    rst    = 1'b0;
    start  = 1'b0;
    cipher = 128'h0;
    key    = 128'h0;
    build_tables();
    repeat (3) @(negedge clk);
    check("reset_plain", plain, 128'h0);
    check("reset_finish", 128'(finish), 128'h0);
    check("reset_busy", 128'(busy), 128'h0);
    rst = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with busy-duration check.
    issue(C1_KEY, C1_CT, C1_PT, ref_round_key(C1_KEY, 10));
    busy_n = 0;
    while (busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    check("busy_cycles", 128'(busy_n), 128'd21);
    drain();

    // FIPS-197 Appendix B, known round key 10.
    issue(B_KEY, B_CT, B_PT, B_RK10);
    drain();

    // Spurious starts while busy, inputs changed after acceptance.
    issue(C1_KEY, C1_CT, C1_PT, ref_round_key(C1_KEY, 10));
    repeat (4) @(negedge clk);
    key = B_KEY; cipher = B_CT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    cipher = {$urandom(), $urandom(), $urandom(), $urandom()};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held for 50 cycles: runs accepted every 22 cycles.
    key = C1_KEY; cipher = C1_CT; start = 1'b1;
    base = cycle_cnt;
    rk = ref_round_key(C1_KEY, 10);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(C1_PT);
      tag_q.push_back(base + 32'(22 * i));
      rk_q.push_back(rk);
    end
    repeat (50) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of a run.
    issue(C1_KEY, C1_CT, C1_PT, ref_round_key(C1_KEY, 10));
    repeat (11) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_plain", plain, 128'h0);
    check("midrst_finish", 128'(finish), 128'h0);
    check("midrst_busy", 128'(busy), 128'h0);
    exp_q.delete();
    tag_q.delete();
    rk_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(B_KEY, B_CT, B_PT, B_RK10);
    drain();

    // Random round trips through the reference encryptor.
    for (int n = 0; n < 1000; n++) begin
      rk  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rpt = {$urandom(), $urandom(), $urandom(), $urandom()};
      rct = ref_encrypt(rk, rpt);
      issue(rk, rct, rpt, ref_round_key(rk, 10));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
